// File: rtl/multiplier_16bit_if.sv
// ---------------------------------------------------------------------------
// multiplier_16bit_if
// Operand, product and capture signals of the 16x16 unsigned multiplier.
//   a, b    : 16-bit unsigned operands        (master -> slave)
//   en      : capture enable for o_q          (master -> slave)
//   o       : combinational product a*b       (slave -> master)
//   o_q     : registered product              (slave -> master)
//   o_valid : high the cycle after a capture  (slave -> master)
// ---------------------------------------------------------------------------
interface multiplier_16bit_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        en;
    logic [31:0] o;
    logic [31:0] o_q;
    logic        o_valid;

    modport master (output a, b, en, input o, o_q, o_valid);
    modport slave  (input a, b, en, output o, o_q, o_valid);
endinterface

// File: rtl/multiplier_16bit.sv
// ---------------------------------------------------------------------------
// multiplier_16bit
// Unsigned 16x16 -> 32 array multiplier. The core is an AND partial-product
// array reduced by 15 rows of 16-bit ripple-carry adders, so bus.o follows
// a*b combinationally. A registered copy (o_q) with a one-cycle valid flag
// is captured on rising clk when en=1.
//   clk   : rising-edge clock for the registered path
//   rst_n : asynchronous active-low reset, clears o_q / o_valid only
//   bus   : multiplier_16bit_if.slave (a, b, en in; o, o_q, o_valid out)
// ---------------------------------------------------------------------------
module multiplier_16bit (
    input  logic               clk,
    input  logic               rst_n,
    multiplier_16bit_if.slave  bus
);
    // pp[i][j] = a[j] & b[i]
    logic [15:0][15:0] pp;
    // acc[r]: running sum entering row r, already shifted right by one
    logic [15:1][15:0] acc;
    logic [15:1][15:0] sum;
    // cy[r][c] is the carry into bit c of row r; cy[r][16] is the row carry-out
    logic [15:1][16:1] cy;
    logic [31:0]       prod;

    logic [31:0] prod_d, prod_q;
    logic        valid_d, valid_q;

    genvar i, r, c;
    generate
        for (i = 0; i < 16; i++) begin : g_pp
            assign pp[i] = bus.a & {16{bus.b[i]}};
        end

        for (r = 1; r < 16; r++) begin : g_row
            // The LSB of each row retires as a product bit, so the next row
            // sees the sum shifted down with the carry-out as its new MSB.
            if (r == 1) begin : g_first
                assign acc[r] = {1'b0, pp[0][15:1]};
            end else begin : g_next
                assign acc[r] = {cy[r-1][16], sum[r-1][15:1]};
            end

            for (c = 0; c < 16; c++) begin : g_col
                if (c == 0) begin : g_ha
                    mul_ha u_ha (
                        .x  (acc[r][c]),
                        .y  (pp[r][c]),
                        .s  (sum[r][c]),
                        .co (cy[r][c+1])
                    );
                end else begin : g_fa
                    mul_fa u_fa (
                        .x   (acc[r][c]),
                        .y   (pp[r][c]),
                        .cin (cy[r][c]),
                        .s   (sum[r][c]),
                        .co  (cy[r][c+1])
                    );
                end
            end

            assign prod[r] = sum[r][0];
        end
    endgenerate

    assign prod[0]      = pp[0][0];
    assign prod[31:16]  = {cy[15][16], sum[15][15:1]};
    assign bus.o        = prod;

    always_comb begin
        prod_d  = prod_q;
        valid_d = 1'b0;
        if (bus.en) begin
            prod_d  = prod;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_q     = prod_q;
    assign bus.o_valid = valid_q;
endmodule

// Full-adder cell of the reduction array.
module mul_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));
endmodule

// Half-adder cell for bit 0 of each row (no carry-in).
module mul_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

// File: tb/tb_multiplier_16bit.sv
// ---------------------------------------------------------------------------
// tb_multiplier_16bit
// Directed vector table for the combinational product, hand-written
// sequences for the registered path and asynchronous reset, then random
// combinational and clocked regression against a reference a*b.
// ---------------------------------------------------------------------------
module tb_multiplier_16bit;
    logic clk;
    logic rst_n;
    multiplier_16bit_if mif ();

    multiplier_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_q;
        checks = 0;
        errors = 0;

        vecs[0]  = '{16'd0,      16'd0,      32'd0};
        vecs[1]  = '{16'd20,     16'd29,     32'h0000_0244};
        vecs[2]  = '{16'd2,      16'd29,     32'd58};
        vecs[3]  = '{16'd200,    16'd29,     32'd5800};
        vecs[4]  = '{16'd210,    16'd2239,   32'h0007_2CAE};
        vecs[5]  = '{16'd8,      16'd2,      32'd16};
        vecs[6]  = '{16'hFFFF,   16'hFFFF,   32'hFFFE_0001};
        vecs[7]  = '{16'hFFFF,   16'h0001,   32'h0000_FFFF};
        vecs[8]  = '{16'h8000,   16'h8000,   32'h4000_0000};
        vecs[9]  = '{16'h0000,   16'hFFFF,   32'd0};
        vecs[10] = '{16'hFFFF,   16'h0000,   32'd0};
        vecs[11] = '{16'h0001,   16'hBEEF,   32'h0000_BEEF};
        vecs[12] = '{16'h1234,   16'h0100,   32'h0012_3400};
        vecs[13] = '{16'hABCD,   16'h8000,   32'h55E6_8000};
        vecs[14] = '{16'h00FF,   16'h00FF,   32'h0000_FE01};

        // Reset state, before any clock edge
        rst_n  = 1'b0;
        mif.a  = '0;
        mif.b  = '0;
        mif.en = 1'b0;
        #1;
        chk("reset_o_q", mif.o_q, 32'd0);
        chk("reset_o_valid", {31'd0, mif.o_valid}, 32'd0);

        // Directed combinational table
        for (int k = 0; k < NVEC; k++) begin
            mif.a = vecs[k].a;
            mif.b = vecs[k].b;
            #1;
            chk($sformatf("vec%0d_o", k), mif.o, vecs[k].exp);
        end

        // Reset does not disturb o; o_q stays cleared
        chk("reset_hold_o_q", mif.o_q, 32'd0);

        // Registered capture then hold
        @(negedge clk);
        rst_n  = 1'b1;
        mif.a  = 16'd210;
        mif.b  = 16'd2239;
        mif.en = 1'b1;
        @(posedge clk);
        #1;
        chk("cap_o_q", mif.o_q, 32'd470190);
        chk("cap_o_valid", {31'd0, mif.o_valid}, 32'd1);
        mif.en = 1'b0;
        mif.a  = 16'd3;
        mif.b  = 16'd3;
        @(posedge clk);
        #1;
        chk("hold_o_q", mif.o_q, 32'd470190);
        chk("hold_o_valid", {31'd0, mif.o_valid}, 32'd0);

        // Async reset between edges
        @(negedge clk);
        mif.a  = 16'd20;
        mif.b  = 16'd29;
        mif.en = 1'b1;
        @(posedge clk);
        #1;
        mif.en = 1'b0;
        chk("pre_rst_o_q", mif.o_q, 32'd580);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_q", mif.o_q, 32'd0);
        chk("async_rst_o_valid", {31'd0, mif.o_valid}, 32'd0);
        chk("async_rst_o", mif.o, 32'd580);

        // Capture pending across reset is discarded
        mif.en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_discard_o_q", mif.o_q, 32'd0);
        chk("rst_discard_o_valid", {31'd0, mif.o_valid}, 32'd0);

        // Random combinational regression
        for (int k = 0; k < 10000; k++) begin
            mif.a = 16'($urandom_range(0, 65535));
            mif.b = 16'($urandom_range(0, 65535));
            #1;
            chk("rand_o", mif.o, 32'(mif.a) * 32'(mif.b));
        end

        // Random clocked regression: o_q follows last cycle's a*b
        @(negedge clk);
        rst_n  = 1'b1;
        mif.en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            mif.a = 16'($urandom_range(0, 65535));
            mif.b = 16'($urandom_range(0, 65535));
            exp_q = 32'(mif.a) * 32'(mif.b);
            @(posedge clk);
            #1;
            chk("rand_o_q", mif.o_q, exp_q);
            chk("rand_o_valid", {31'd0, mif.o_valid}, 32'd1);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiplier_16bit.md
Name: multiplier_16bit

Overview:
Unsigned 16x16 array multiplier producing a full 32-bit product. The core is a purely combinational partial-product AND array reduced by rows of ripple-carry full adders. Its output `o` is available in the same time step as the inputs. A registered copy of the product, with a valid flag, serves synchronous consumers in the datapath.

Parameters:
- None. Operand widths are fixed at 16 bits; the product width is fixed at 32 bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- en  input  1  capture enable for the registered product
- o  output  32  combinational product a*b
- o_q  output  32  registered product
- o_valid  output  1  high for the cycle after a capture

Behaviour:
- Arithmetic: unsigned only. o = a*b, exact, 32 bits wide; no overflow is possible.
  - Max case: 0xFFFF*0xFFFF = 0xFFFE0001.
- Structure of `o`:
  - 256 partial-product bits pp[i][j] = a[j] & b[i].
  - 15 rows of 16-bit ripple-carry adders, built from full-adder/half-adder cells.
  - Row i adds the shifted pp row i to the running sum of the previous rows.
  - The LSB of each row's sum drops out as product bit i; the final row's sum plus carry-out forms o[31:15].
  - The multiplier must not use the behavioural `*` operator; it is built structurally or as explicit gate-level equations.
- `o` timing:
  - Purely combinational: no clock, no reset dependency.
  - `o` must settle to the correct value within the combinational propagation delay after any change of `a` or `b`.
  - Zero-delay RTL: correct by the next delta; the bench samples 1 time unit after stimulus.
- Registered path:
  - On a rising clk with en=1: o_q <= o and o_valid <= 1.
  - On a rising clk with en=0: o_q holds its value and o_valid <= 0.
  - Latency: 1 clock from operand capture to o_q.
- Reset:
  - rst_n low asynchronously forces o_q=0 and o_valid=0, immediately and regardless of clk.
  - Reset asserted mid-operation discards any pending capture.
  - After rst_n rises, the first capture occurs at the first rising clk with en=1.
  - Reset does not affect `o`, which continues to track a*b.
- Boundary conditions:
  - a=0 or b=0 gives 0.
  - a=1 gives o = b zero-extended.
  - b = 2^k gives a << k.
  - Operands with all bits set exercise the full carry chain with no truncation.
- X-propagation:
  - Any X on a or b may propagate to o.
  - o_q and o_valid are never X after reset.

Test Plan:
- Combinational sweep, clk idle, 1 time unit settle per vector:
  - 0*0 -> o=0
  - 20*29 -> o=580 (0x244)
  - 2*29 -> o=58
  - 200*29 -> o=5800
  - 210*2239 -> o=470190 (0x72CAE)
  - 8*2 -> o=16
- Extremes: 0xFFFF*0xFFFF -> o=0xFFFE0001; 0xFFFF*1 -> o=0x0000FFFF; 0x8000*0x8000 -> o=0x40000000.
- Registered path:
  - rst_n=0 -> o_q=0, o_valid=0 with no clock edge.
  - Release reset, apply a=210, b=2239, en=1 -> after one rising clk, o_q=470190 and o_valid=1.
  - Next edge with en=0 -> o_q holds 470190 and o_valid=0.
- Async reset mid-stream: with o_q=580, assert rst_n low between clock edges -> o_q=0 and o_valid=0 immediately, while o still equals a*b.
- Random regression: 10,000 random a/b pairs -> o equals the reference a*b exactly. With en=1 each cycle, o_q equals the previous cycle's a*b.
